// File: rtl/aoi_pkg.sv
// aoi_pkg: shared constants and types for the aoi cell
package aoi_pkg;
    localparam logic OQ_RST_VAL = 1'b1;
    localparam int DEF_CNT_W = 16;
    typedef logic [DEF_CNT_W-1:0] cnt_t;
endpackage

// File: rtl/aoi_core.sv
// aoi_core: combinational AOI22, o = ~((a1 & a2) | (b1 & b2))
module aoi_core (
    input  logic a1,
    input  logic a2,
    input  logic b1,
    input  logic b2,
    output logic term_a,
    output logic term_b,
    output logic o
);
    always_comb begin
        term_a = a1 & a2;
        term_b = b1 & b2;
        o = ~(term_a | term_b);
    end
endmodule

// File: rtl/aoi.sv
// aoi: AOI22 with registered copy; AOI_TOGGLE_CNT_EN adds a saturating o_q toggle counter
module aoi
    import aoi_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a1,
    input  logic             a2,
    input  logic             b1,
    input  logic             b2,
    output logic             o,
    output logic             o_q,
    output logic             term_a,
    output logic             term_b,
    input  logic             clr_cnt,
    output logic [CNT_W-1:0] toggle_cnt
);
    aoi_core u_core (
        .a1(a1),
        .a2(a2),
        .b1(b1),
        .b2(b2),
        .term_a(term_a),
        .term_b(term_b),
        .o(o)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) o_q <= OQ_RST_VAL;
        else o_q <= o;
    end
`ifdef AOI_TOGGLE_CNT_EN
    logic [CNT_W-1:0] cnt_d, cnt_q;
    // o != o_q here means o_q changes at this edge; clear wins over increment
    always_comb begin
        cnt_d = clr_cnt ? '0 : (o != o_q && cnt_q != {CNT_W{1'b1}}) ? cnt_q + CNT_W'(1) : cnt_q;
        toggle_cnt = cnt_q;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else cnt_q <= cnt_d;
    end
`else
    logic unused_clr;
    always_comb begin
        unused_clr = clr_cnt;
        toggle_cnt = '0;
    end
`endif
endmodule

// File: tb/tb_aoi.sv
// tb_aoi: scoreboard bench for aoi, main instance plus a CNT_W=2 instance for saturation
module tb_aoi;
`ifdef AOI_TOGGLE_CNT_EN
    localparam bit EN = 1'b1;
`else
    localparam bit EN = 1'b0;
`endif
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic a1 = 0, a2 = 0, b1 = 0, b2 = 0, clr_cnt = 0;
    logic o, o_q, term_a, term_b, o2, o_q2, ta2, tb2;
    logic [15:0] cnt16;
    logic [1:0] cnt2;
    int total = 0, bad = 0;
    typedef struct {
        logic oq;
        int c16;
        int c2;
    } exp_t;
    exp_t sb[$];
    logic m_oq = 1'b1;
    int m16 = 0, m2 = 0;

    aoi #(.CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .a1(a1), .a2(a2), .b1(b1), .b2(b2),
        .o(o), .o_q(o_q), .term_a(term_a), .term_b(term_b),
        .clr_cnt(clr_cnt), .toggle_cnt(cnt16)
    );
    aoi #(.CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .a1(a1), .a2(a2), .b1(b1), .b2(b2),
        .o(o2), .o_q(o_q2), .term_a(ta2), .term_b(tb2),
        .clr_cnt(clr_cnt), .toggle_cnt(cnt2)
    );

    always #5 clk = ~clk;

    function automatic logic exp_o(input logic [3:0] c);
        return !(c inside {4'b0011, 4'b0111, 4'b1011, 4'b1100, 4'b1101, 4'b1110, 4'b1111});
    endfunction

    task automatic set_in(input logic [3:0] c);
        {a1, a2, b1, b2} = c;
    endtask

    task automatic model_reset();
        m_oq = 1'b1;
        m16 = 0;
        m2 = 0;
        sb.delete();
    endtask

    // called at a negedge; drives one code, checks o before the edge and o_q/counts after it
    task automatic drive_cycle(input logic [3:0] c, input logic clr);
        exp_t e;
        logic eo;
        logic prev;
        set_in(c);
        clr_cnt = clr;
        eo = exp_o(c);
        prev = m_oq;
        if (clr) begin
            m16 = 0;
            m2 = 0;
        end else if (eo != m_oq) begin
            m16 = (m16 < 65535) ? m16 + 1 : m16;
            m2 = (m2 < 3) ? m2 + 1 : m2;
        end
        m_oq = eo;
        e.oq = eo;
        e.c16 = EN ? m16 : 0;
        e.c2 = EN ? m2 : 0;
        sb.push_back(e);
        #1;
        total++;
        if (o !== eo) begin bad++; $display("FAIL comb_o code=%b got=%b want=%b", c, o, eo); end
        total++;
        if (o_q !== prev) begin bad++; $display("FAIL oq_pre_edge code=%b got=%b want=%b", c, o_q, prev); end
        @(posedge clk);
        #1;
        e = sb.pop_front();
        total++;
        if (o_q !== e.oq || o_q2 !== e.oq) begin
            bad++; $display("FAIL oq code=%b got=%b/%b want=%b", c, o_q, o_q2, e.oq);
        end
        total++;
        if (cnt16 !== 16'(e.c16)) begin bad++; $display("FAIL cnt16 code=%b got=%0d want=%0d", c, cnt16, e.c16); end
        total++;
        if (cnt2 !== 2'(e.c2)) begin bad++; $display("FAIL cnt2 code=%b got=%0d want=%0d", c, cnt2, e.c2); end
        @(negedge clk);
        clr_cnt = 1'b0;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (o_q !== 1'b1 || o_q2 !== 1'b1) begin bad++; $display("FAIL reset_oq got=%b/%b want=1", o_q, o_q2); end
        total++;
        if (cnt16 !== 16'd0 || cnt2 !== 2'd0) begin bad++; $display("FAIL reset_cnt got=%0d/%0d want=0", cnt16, cnt2); end
        total++;
        if (o !== 1'b1) begin bad++; $display("FAIL reset_o got=%b want=1", o); end
    endtask

    task automatic test_sweep();
        for (int i = 0; i < 16; i++) begin
            logic [3:0] c;
            c = 4'(i);
            set_in(c);
            #100;
            total++;
            if (o !== exp_o(c) || o2 !== exp_o(c)) begin
                bad++; $display("FAIL sweep_o code=%b got=%b want=%b", c, o, exp_o(c));
            end
            total++;
            if (term_a !== (c[3] & c[2]) || term_b !== (c[1] & c[0])) begin
                bad++; $display("FAIL sweep_terms code=%b got=%b%b want=%b%b", c, term_a, term_b, c[3] & c[2], c[1] & c[0]);
            end
        end
        total++;
        if (o_q !== 1'b1) begin bad++; $display("FAIL sweep_oq_held got=%b want=1", o_q); end
    endtask

    task automatic test_release();
        @(negedge clk);
        model_reset();
        set_in(4'b0000);
        rst_n = 1'b1;
        drive_cycle(4'b0000, 1'b0);
    endtask

    task automatic test_registered();
        drive_cycle(4'b1100, 1'b0);
        drive_cycle(4'b1100, 1'b0);
    endtask

    task automatic test_reset_mid();
        drive_cycle(4'b1111, 1'b0);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (o_q !== 1'b1 || o_q2 !== 1'b1) begin bad++; $display("FAIL mid_reset_oq got=%b/%b want=1", o_q, o_q2); end
        total++;
        if (cnt16 !== 16'd0 || cnt2 !== 2'd0) begin bad++; $display("FAIL mid_reset_cnt got=%0d/%0d want=0", cnt16, cnt2); end
        set_in(4'b1100);
        #1;
        total++;
        if (o !== 1'b0) begin bad++; $display("FAIL mid_reset_o got=%b want=0", o); end
        @(negedge clk);
        model_reset();
        rst_n = 1'b1;
        drive_cycle(4'b1100, 1'b0);
    endtask

    task automatic test_toggle();
        drive_cycle(4'b1100, 1'b1);
        for (int i = 0; i < 10; i++) drive_cycle((i % 2 == 0) ? 4'b0000 : 4'b1111, 1'b0);
        for (int i = 0; i < 3; i++) drive_cycle(4'b1111, 1'b0);
    endtask

    task automatic test_clear();
        drive_cycle(4'b0000, 1'b1);
        drive_cycle(4'b1111, 1'b0);
        drive_cycle(4'b1111, 1'b1);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 24; i++) drive_cycle(4'($urandom_range(15, 0)), ($urandom_range(7, 0) == 0));
    endtask

    initial begin
        test_reset();
        test_sweep();
        test_release();
        test_registered();
        test_reset_mid();
        test_toggle();
        test_clear();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
